jk_exc_sequencer: RTL and testbench

JK_EXC_SEQUENCER -- requirements
Module: jk_exc_sequencer

---
 rtl/jk_pkg.sv | 27 ++
 rtl/jk_stage.sv | 27 ++
 rtl/jk_exc_sequencer.sv | 88 ++++++++
 tb/tb_jk_exc_sequencer.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared FSM encoding and JK excitation-table constants for the JK excitation sequencer.
package jk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Excitation pairs packed as {J, K}; don't-care entries resolve to 0.
    localparam logic [1:0] EXC_HOLD0 = 2'b00;
    localparam logic [1:0] EXC_SET   = 2'b10;
    localparam logic [1:0] EXC_RESET = 2'b01;
    localparam logic [1:0] EXC_HOLD1 = 2'b00;

    function automatic logic [1:0] jk_excite(input logic cur, input logic nxt);
        logic [1:0] jk;
        case ({cur, nxt})
            2'b00:   jk = EXC_HOLD0;
            2'b01:   jk = EXC_SET;
            2'b10:   jk = EXC_RESET;
            default: jk = EXC_HOLD1;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_stage.sv
// One-bit JK register; the next state follows the JK characteristic equation.
module jk_stage (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = (j & ~q_q) | (~k & q_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_exc_sequencer.sv
// Walks a bank of JK flops one count per cycle toward a latched target,
// deriving the J/K excitations from the current and desired next state.
module jk_exc_sequencer
    import jk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] target,
    output logic             ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec,
    output logic             done,
    output logic [WIDTH-1:0] steps
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] steps_q, steps_d;
    logic [WIDTH-1:0] desired;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        jk_stage u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (j_vec[i]),
            .k     (k_vec[i]),
            .q     (q[i])
        );
    end

    // RUN is only entered with target != q, so the step never wraps.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        steps_d = steps_q;
        j_vec   = '0;
        k_vec   = '0;
        desired = (tgt_q > q) ? (q + WIDTH'(1)) : (q - WIDTH'(1));

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tgt_d   = target;
                    steps_d = '0;
                    state_d = (target == q) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (rst_n) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        {j_vec[i], k_vec[i]} = jk_excite(q[i], desired[i]);
                    end
                end
                steps_d = steps_q + WIDTH'(1);
                if (desired == tgt_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tgt_q   <= '0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            steps_q <= steps_d;
        end
    end

    assign ready = (state_q == ST_IDLE);
    assign done  = (state_q == ST_DONE);
    assign steps = steps_q;

endmodule

// File: tb/tb_jk_exc_sequencer.sv
// Directed bench for jk_exc_sequencer (WIDTH=4) with hand-computed expectations.
module tb_jk_exc_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] target;
    logic       ready;
    logic [3:0] q;
    logic [3:0] j_vec;
    logic [3:0] k_vec;
    logic       done;
    logic [3:0] steps;

    int checks   = 0;
    int failures = 0;

    jk_exc_sequencer #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .target (target),
        .ready  (ready),
        .q      (q),
        .j_vec  (j_vec),
        .k_vec  (k_vec),
        .done   (done),
        .steps  (steps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change only at the falling edge, where outputs are also sampled.
    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic s, input logic [3:0] t);
        start  = s;
        target = t;
    endtask

    // Accepts a walk to tgt and follows it with a bench-side model of q.
    // glitch_at >= 0 pulses start with a bogus target at that RUN cycle.
    task automatic runWalk(input logic [3:0] tgt, input logic [3:0] exp_steps, input int glitch_at);
        logic [3:0] qm;
        logic [3:0] nm;
        int n;
        qm = q;
        checkOutput("ready_before_accept", {7'd0, ready}, 8'd1);
        applyStimulus(1'b1, tgt);
        stepCycle();
        applyStimulus(1'b0, 4'd0);
        n = 0;
        while (qm != tgt && n < 20) begin
            nm = (tgt > qm) ? qm + 4'd1 : qm - 4'd1;
            checkOutput("run_ready", {7'd0, ready}, 8'd0);
            checkOutput("run_done", {7'd0, done}, 8'd0);
            checkOutput("run_j", {4'd0, j_vec}, {4'd0, ~qm & nm});
            checkOutput("run_k", {4'd0, k_vec}, {4'd0, qm & ~nm});
            if (qm == 4'd7 && tgt == 4'd15) begin
                checkOutput("j_7to8", {4'd0, j_vec}, 8'h08);
                checkOutput("k_7to8", {4'd0, k_vec}, 8'h07);
            end
            if (qm == 4'd5 && tgt == 4'd2) begin
                checkOutput("j_5to4", {4'd0, j_vec}, 8'h00);
                checkOutput("k_5to4", {4'd0, k_vec}, 8'h01);
            end
            if (n == glitch_at) applyStimulus(1'b1, 4'd3);
            stepCycle();
            applyStimulus(1'b0, 4'd0);
            qm = nm;
            n++;
            checkOutput("run_q", {4'd0, q}, {4'd0, qm});
        end
        checkOutput("done_pulse", {7'd0, done}, 8'd1);
        checkOutput("done_steps", {4'd0, steps}, {4'd0, exp_steps});
        checkOutput("done_q", {4'd0, q}, {4'd0, tgt});
        checkOutput("done_j", {4'd0, j_vec}, 8'd0);
        checkOutput("done_k", {4'd0, k_vec}, 8'd0);
        stepCycle();
        checkOutput("post_done", {7'd0, done}, 8'd0);
        checkOutput("post_ready", {7'd0, ready}, 8'd1);
        checkOutput("post_steps", {4'd0, steps}, {4'd0, exp_steps});
        checkOutput("post_q", {4'd0, q}, {4'd0, tgt});
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b1, 4'd9);
        @(negedge clk);
        stepCycle();
        checkOutput("rst_q", {4'd0, q}, 8'd0);
        checkOutput("rst_ready", {7'd0, ready}, 8'd1);
        checkOutput("rst_done", {7'd0, done}, 8'd0);
        checkOutput("rst_steps", {4'd0, steps}, 8'd0);
        checkOutput("rst_j", {4'd0, j_vec}, 8'd0);
        checkOutput("rst_k", {4'd0, k_vec}, 8'd0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 4'd0);
        stepCycle();
        checkOutput("rst_start_ignored_q", {4'd0, q}, 8'd0);
        checkOutput("rst_start_ignored_ready", {7'd0, ready}, 8'd1);

        runWalk(4'd5, 4'd5, -1);
        runWalk(4'd2, 4'd3, -1);
        runWalk(4'd7, 4'd5, -1);
        runWalk(4'd7, 4'd0, -1);
        runWalk(4'd0, 4'd7, -1);
        runWalk(4'd15, 4'd15, -1);
        runWalk(4'd10, 4'd5, 1);
        runWalk(4'd0, 4'd10, -1);

        // Walk toward 9, then reset during the third RUN cycle.
        applyStimulus(1'b1, 4'd9);
        stepCycle();
        applyStimulus(1'b0, 4'd0);
        stepCycle();
        stepCycle();
        checkOutput("abort_pre_q", {4'd0, q}, 8'd2);
        rst_n = 1'b0;
        stepCycle();
        checkOutput("abort_q", {4'd0, q}, 8'd0);
        checkOutput("abort_done", {7'd0, done}, 8'd0);
        checkOutput("abort_steps", {4'd0, steps}, 8'd0);
        rst_n = 1'b1;
        stepCycle();
        checkOutput("abort_ready", {7'd0, ready}, 8'd1);
        checkOutput("abort_done_after", {7'd0, done}, 8'd0);
        runWalk(4'd6, 4'd6, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
